aes128_encryption: RTL

- Iterative AES-128 encryption core. It is the forward counterpart of the existing decryption block and shares its flag-based load/done handshake.
- Executes one cipher round per clock. Round keys are expanded on the fly.
- Sits beside the decryption block in the crypto datapath; the same system controller drives both.

---
 rtl/aes_pkg.sv | 69 ++++++
 rtl/aes128_encryption_if.sv | 24 ++
 rtl/aes_sbox.sv | 9 +
 rtl/aes128_encryption.sv | 123 ++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, state enum, S-box table and GF(2^8) helpers
package aes_pkg;

    localparam int AES_NR = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_state_e;

    // Byte 0x00 maps from the most significant byte of the table.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Column bytes a0..a3 with a0 in the most significant position.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes128_encryption_if.sv
// rtl/aes128_encryption_if.sv - flag-based load/done handshake shared by the AES blocks
interface aes128_encryption_if;
    logic         inputsLoadedFlag;
    logic [127:0] inputData;
    logic [127:0] key;
    logic [127:0] outputData;
    logic         dataEncryptedFlag;

    modport master (
        output inputsLoadedFlag,
        output inputData,
        output key,
        input  outputData,
        input  dataEncryptedFlag
    );

    modport slave (
        input  inputsLoadedFlag,
        input  inputData,
        input  key,
        output outputData,
        output dataEncryptedFlag
    );
endinterface

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    assign o_byte = sbox(i_byte);
endmodule

// File: rtl/aes128_encryption.sv
// rtl/aes128_encryption.sv - iterative AES-128 encryptor, one round per clock; AES_ENC_DEBUG_EN adds debug ports
module aes128_encryption
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic clock,
    input  logic resetModule,
    aes128_encryption_if.slave bus
`ifdef AES_ENC_DEBUG_EN
    ,
    output logic [3:0]   debugRound,
    output logic [127:0] debugRoundKey
`endif
);

    aes_state_e   r_state, w_state_nxt;
    logic [3:0]   r_round, w_round_nxt;
    logic [127:0] r_data, w_data_nxt;
    logic [127:0] r_key, w_key_nxt;
    logic [127:0] r_out, w_out_nxt;
    logic         r_done, w_done_nxt;

    logic [7:0]   w_sub [16];
    logic [127:0] w_shift;
    logic [127:0] w_mixed;
    logic [127:0] w_final;
    logic [31:0]  w_rot, w_subword;
    logic [31:0]  w_k0, w_k1, w_k2, w_k3;
    logic [127:0] w_round_key;

    // SubBytes then ShiftRows: row r of column c takes column (c + r) mod 4.
    for (genvar i = 0; i < 16; i++) begin : g_subbytes
        aes_sbox u_sbox (.i_byte(r_data[127-8*i -: 8]), .o_byte(w_sub[i]));
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign w_shift[127-8*(r+4*c) -: 8] = w_sub[r + 4*((c + r) % 4)];
        end
        assign w_mixed[127-32*c -: 32] = mix_column(w_shift[127-32*c -: 32]) ^ w_round_key[127-32*c -: 32];
    end

    assign w_final = w_shift ^ w_round_key;

    assign w_rot = {r_key[23:0], r_key[31:24]};
    for (genvar i = 0; i < 4; i++) begin : g_subword
        aes_sbox u_sbox (.i_byte(w_rot[31-8*i -: 8]), .o_byte(w_subword[31-8*i -: 8]));
    end

    assign w_k0        = r_key[127:96] ^ w_subword ^ {rcon(r_round), 24'h000000};
    assign w_k1        = r_key[95:64] ^ w_k0;
    assign w_k2        = r_key[63:32] ^ w_k1;
    assign w_k3        = r_key[31:0]  ^ w_k2;
    assign w_round_key = {w_k0, w_k1, w_k2, w_k3};

    always_ff @(posedge clock or negedge resetModule) begin
        if (!resetModule) begin
            r_state <= IDLE;
            r_round <= 4'd0;
            r_data  <= '0;
            r_key   <= '0;
            r_out   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_round <= w_round_nxt;
            r_data  <= w_data_nxt;
            r_key   <= w_key_nxt;
            r_out   <= w_out_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_round_nxt = r_round;
        w_data_nxt  = r_data;
        w_key_nxt   = r_key;
        w_out_nxt   = r_out;
        w_done_nxt  = r_done;
        case (r_state)
            IDLE: begin
                if (bus.inputsLoadedFlag) begin
                    w_data_nxt  = bus.inputData ^ bus.key;
                    w_key_nxt   = bus.key;
                    w_round_nxt = 4'd1;
                    w_state_nxt = ROUND;
                end
            end
            ROUND: begin
                w_key_nxt = w_round_key;
                if (r_round == 4'(NR)) begin
                    w_data_nxt  = w_final;
                    w_out_nxt   = w_final;
                    w_done_nxt  = 1'b1;
                    w_round_nxt = 4'd0;
                    w_state_nxt = DONE;
                end else begin
                    w_data_nxt  = w_mixed;
                    w_round_nxt = r_round + 4'd1;
                end
            end
            DONE: begin
                // Leaving DONE always passes through IDLE, so a held request never retriggers.
                if (!bus.inputsLoadedFlag) begin
                    w_done_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.outputData        = r_out;
    assign bus.dataEncryptedFlag = r_done;

`ifdef AES_ENC_DEBUG_EN
    assign debugRound    = (r_state == ROUND) ? r_round : 4'd0;
    assign debugRoundKey = r_key;
`endif

endmodule
